product_display_ctrl: RTL and testbench

- Sequences the four-digit seven-segment scanner for the serial-parallel multiplier result.
- Accepts a 16-bit signed product through a valid/ready handshake and converts it to five BCD digits with a multi-cycle shift-add-3 (double-dabble) engine.
- Drives seg0..seg3 with active-low segment codes: seg3 carries the sign, seg2..seg0 show a 3-digit window.
- The window is scrolled across the 5 digits by single-cycle button pulses from the existing debouncers.

---
 rtl/product_display_ctrl_pkg.sv | 31 +++
 rtl/product_display_ctrl_bcd_seg_decode.sv | 18 +
 rtl/product_display_ctrl.sv | 148 ++++++++++++++
 tb/tb_product_display_ctrl.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/product_display_ctrl_pkg.sv
// Shared constants for the product display controller: segment codes, FSM states, defaults.
// Segment codes are active-low, bit order {g,f,e,d,c,b,a}.
package product_display_ctrl_pkg;

    localparam int WIDTH_DEF = 16;
    localparam int NDIG_DEF  = 5;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_MINUS = 7'b0111111;

    // Entry i holds the code for digit i
    localparam logic [9:0][6:0] SEG_CODE = {
        7'b0010000,  // 9
        7'b0000000,  // 8
        7'b1111000,  // 7
        7'b0000010,  // 6
        7'b0010010,  // 5
        7'b0011001,  // 4
        7'b0110000,  // 3
        7'b0100100,  // 2
        7'b1111001,  // 1
        7'b1000000   // 0
    };

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CONV   = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

endpackage

// File: rtl/product_display_ctrl_bcd_seg_decode.sv
// BCD digit to active-low seven-segment code.
// Latency: combinational. Backpressure: none.
// Non-BCD inputs (10..15) blank the digit.
module bcd_seg_decode
    import product_display_ctrl_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        if (bcd <= 4'd9) begin
            seg = SEG_CODE[bcd];
        end
    end

endmodule

// File: rtl/product_display_ctrl.sv
// Signed product -> sign + NDIG BCD digits (double-dabble) -> scrollable 3-digit window on 7-seg.
// Latency: done and new segments appear WIDTH+1 edges after the accept edge.
// Backpressure: prod_ready low while converting; prod_valid is ignored then, not queued.
module product_display_ctrl
    import product_display_ctrl_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int NDIG  = NDIG_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] prod,
    input  logic             prod_valid,
    output logic             prod_ready,
    input  logic             btn_left,
    input  logic             btn_right,
    output logic             busy,
    output logic             done,
    output logic [6:0]       seg0,
    output logic [6:0]       seg1,
    output logic [6:0]       seg2,
    output logic [6:0]       seg3
);

    localparam int BW   = 4 * NDIG;
    localparam int CW   = $clog2(WIDTH + 1);
    localparam int WW   = $clog2(NDIG - 2);
    localparam int IW   = $clog2(NDIG);
    localparam int WMAX = NDIG - 3;

    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [WIDTH-1:0]       mag_q, mag_d;
    logic [BW-1:0]          bcd_q, bcd_d;
    logic [BW-1:0]          bcd_adj;
    logic                   sign_cap_q, sign_cap_d;
    logic [NDIG-1:0][3:0]   dig_q, dig_d;
    logic                   sign_q, sign_d;
    logic [WW-1:0]          win_q, win_d;
    logic                   done_q, done_d;
    logic [6:0]             seg0_q, seg1_q, seg2_q, seg3_q;
    logic [6:0]             seg0_d, seg1_d, seg2_d, seg3_d;
    logic [IW-1:0]          idx0, idx1, idx2;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        mag_d      = mag_q;
        bcd_d      = bcd_q;
        sign_cap_d = sign_cap_q;
        dig_d      = dig_q;
        sign_d     = sign_q;
        win_d      = win_q;
        done_d     = 1'b0;

        for (int i = 0; i < NDIG; i++) begin
            bcd_adj[4*i +: 4] = (bcd_q[4*i +: 4] >= 4'd5) ? bcd_q[4*i +: 4] + 4'd3
                                                          : bcd_q[4*i +: 4];
        end

        // Simultaneous left+right presses cancel out
        if (btn_left && !btn_right && win_q != WW'(WMAX)) begin
            win_d = win_q + 1'b1;
        end else if (btn_right && !btn_left && win_q != '0) begin
            win_d = win_q - 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (prod_valid) begin
                    sign_cap_d = prod[WIDTH-1];
                    mag_d      = prod[WIDTH-1] ? (~prod + 1'b1) : prod;
                    bcd_d      = '0;
                    cnt_d      = CW'(WIDTH);
                    state_d    = ST_CONV;
                end
            end
            ST_CONV: begin
                bcd_d = {bcd_adj[BW-2:0], mag_q[WIDTH-1]};
                mag_d = {mag_q[WIDTH-2:0], 1'b0};
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CW'(1)) begin
                    state_d = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                dig_d   = bcd_q;
                sign_d  = sign_cap_q;
                win_d   = '0;
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Segments decode the next-state digits so they land together with the register update
    assign idx0 = IW'(win_d);
    assign idx1 = idx0 + IW'(1);
    assign idx2 = idx0 + IW'(2);

    bcd_seg_decode u_dec0 (.bcd(dig_d[idx0]), .seg(seg0_d));
    bcd_seg_decode u_dec1 (.bcd(dig_d[idx1]), .seg(seg1_d));
    bcd_seg_decode u_dec2 (.bcd(dig_d[idx2]), .seg(seg2_d));

    assign seg3_d = sign_d ? SEG_MINUS : SEG_BLANK;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            mag_q      <= '0;
            bcd_q      <= '0;
            sign_cap_q <= 1'b0;
            dig_q      <= '0;
            sign_q     <= 1'b0;
            win_q      <= '0;
            done_q     <= 1'b0;
            seg0_q     <= SEG_CODE[0];
            seg1_q     <= SEG_CODE[0];
            seg2_q     <= SEG_CODE[0];
            seg3_q     <= SEG_BLANK;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            mag_q      <= mag_d;
            bcd_q      <= bcd_d;
            sign_cap_q <= sign_cap_d;
            dig_q      <= dig_d;
            sign_q     <= sign_d;
            win_q      <= win_d;
            done_q     <= done_d;
            seg0_q     <= seg0_d;
            seg1_q     <= seg1_d;
            seg2_q     <= seg2_d;
            seg3_q     <= seg3_d;
        end
    end

    assign prod_ready = (state_q == ST_IDLE);
    assign busy       = !prod_ready;
    assign done       = done_q;
    assign seg0       = seg0_q;
    assign seg1       = seg1_q;
    assign seg2       = seg2_q;
    assign seg3       = seg3_q;

endmodule

// File: tb/tb_product_display_ctrl.sv
// Directed bench for product_display_ctrl: conversion vector table plus hand sequences.
module tb_product_display_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] prod = '0;
    logic        prod_valid = 1'b0;
    logic        prod_ready;
    logic        btn_left = 1'b0;
    logic        btn_right = 1'b0;
    logic        busy;
    logic        done;
    logic [6:0]  seg0, seg1, seg2, seg3;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [15:0] prod;
        logic        sgn;
        logic [3:0]  e2;
        logic [3:0]  e1;
        logic [3:0]  e0;
    } vec_t;

    vec_t vecs [6];

    product_display_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .prod       (prod),
        .prod_valid (prod_valid),
        .prod_ready (prod_ready),
        .btn_left   (btn_left),
        .btn_right  (btn_right),
        .busy       (busy),
        .done       (done),
        .seg0       (seg0),
        .seg1       (seg1),
        .seg2       (seg2),
        .seg3       (seg3)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        case (d)
            4'd0: seg_of = 7'b1000000;
            4'd1: seg_of = 7'b1111001;
            4'd2: seg_of = 7'b0100100;
            4'd3: seg_of = 7'b0110000;
            4'd4: seg_of = 7'b0011001;
            4'd5: seg_of = 7'b0010010;
            4'd6: seg_of = 7'b0000010;
            4'd7: seg_of = 7'b1111000;
            4'd8: seg_of = 7'b0000000;
            4'd9: seg_of = 7'b0010000;
            default: seg_of = 7'b1111111;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_win(input string nm, input logic [3:0] d2, input logic [3:0] d1,
                           input logic [3:0] d0);
        chk({nm, "_seg2"}, {25'd0, seg2}, {25'd0, seg_of(d2)});
        chk({nm, "_seg1"}, {25'd0, seg1}, {25'd0, seg_of(d1)});
        chk({nm, "_seg0"}, {25'd0, seg0}, {25'd0, seg_of(d0)});
    endtask

    // Accept p on the next edge; return edges-to-done and number of busy samples
    task automatic do_conv(input logic [15:0] p, output int lat, output int busy_n);
        lat    = -1;
        busy_n = 0;
        prod       = p;
        prod_valid = 1'b1;
        @(posedge clk);
        #1;
        prod_valid = 1'b0;
        if (busy) busy_n++;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = n;
                break;
            end
            if (busy) busy_n++;
        end
    endtask

    task automatic pulse(input logic l, input logic r);
        btn_left  = l;
        btn_right = r;
        @(posedge clk);
        #1;
        btn_left  = 1'b0;
        btn_right = 1'b0;
    endtask

    initial begin
        int lat, bn;
        int seen;

        vecs[0] = '{16'd1234,  1'b0, 4'd2, 4'd3, 4'd4};
        vecs[1] = '{16'h8000,  1'b1, 4'd7, 4'd6, 4'd8};
        vecs[2] = '{16'd0,     1'b0, 4'd0, 4'd0, 4'd0};
        vecs[3] = '{16'hFFFF,  1'b1, 4'd0, 4'd0, 4'd1};
        vecs[4] = '{16'd32767, 1'b0, 4'd7, 4'd6, 4'd7};
        vecs[5] = '{16'hFC19,  1'b1, 4'd9, 4'd9, 4'd9};

        // Reset
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", {31'd0, prod_ready}, 32'd1);
        chk("rst_busy",  {31'd0, busy}, 32'd0);
        chk("rst_done",  {31'd0, done}, 32'd0);
        chk("rst_seg3",  {25'd0, seg3}, {25'd0, 7'b1111111});
        chk_win("rst", 4'd0, 4'd0, 4'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Conversion table
        for (int i = 0; i < 6; i++) begin
            do_conv(vecs[i].prod, lat, bn);
            chk("vec_latency", lat, 32'd17);
            chk("vec_busy_cycles", bn, 32'd17);
            chk("vec_ready_at_done", {31'd0, prod_ready}, 32'd1);
            chk("vec_seg3", {25'd0, seg3}, {25'd0, vecs[i].sgn ? 7'b0111111 : 7'b1111111});
            chk_win("vec", vecs[i].e2, vecs[i].e1, vecs[i].e0);
            @(posedge clk);
            #1;
            chk("vec_done_one_cycle", {31'd0, done}, 32'd0);
        end

        // Window scroll on -32768 (digits 3 2 7 6 8)
        do_conv(16'h8000, lat, bn);
        chk("m_latency", lat, 32'd17);
        chk_win("m_win0", 4'd7, 4'd6, 4'd8);
        pulse(1'b1, 1'b0);
        chk_win("m_win1", 4'd2, 4'd7, 4'd6);
        pulse(1'b1, 1'b0);
        chk_win("m_win2", 4'd3, 4'd2, 4'd7);
        pulse(1'b1, 1'b0);
        chk_win("m_sat_left", 4'd3, 4'd2, 4'd7);
        pulse(1'b1, 1'b1);
        chk_win("m_both", 4'd3, 4'd2, 4'd7);
        chk("m_both_seg3", {25'd0, seg3}, {25'd0, 7'b0111111});
        pulse(1'b0, 1'b1);
        pulse(1'b0, 1'b1);
        pulse(1'b0, 1'b1);
        chk_win("m_sat_right", 4'd7, 4'd6, 4'd8);

        // prod_valid during conversion is ignored
        prod       = 16'd99;
        prod_valid = 1'b1;
        @(posedge clk);
        #1;
        prod = 16'd5;
        repeat (3) @(posedge clk);
        #1;
        chk("ign_ready_low", {31'd0, prod_ready}, 32'd0);
        prod_valid = 1'b0;
        seen = 0;
        for (int n = 0; n < 40 && seen == 0; n++) begin
            @(posedge clk);
            #1;
            if (done) seen = 1;
        end
        chk("ign_done_seen", seen, 32'd1);
        chk_win("ign_99", 4'd0, 4'd9, 4'd9);
        repeat (3) @(posedge clk);
        #1;
        chk("ign_no_second", {31'd0, busy}, 32'd0);

        // Window returns to 0 on commit; old result held while busy
        pulse(1'b1, 1'b0);
        chk_win("w1_before", 4'd0, 4'd0, 4'd9);
        prod       = 16'd42;
        prod_valid = 1'b1;
        @(posedge clk);
        #1;
        prod_valid = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        chk("w1_busy_mid", {31'd0, busy}, 32'd1);
        chk_win("w1_held", 4'd0, 4'd0, 4'd9);
        seen = 0;
        for (int n = 0; n < 40 && seen == 0; n++) begin
            @(posedge clk);
            #1;
            if (done) seen = 1;
        end
        chk("w1_done_seen", seen, 32'd1);
        chk_win("w1_after", 4'd0, 4'd4, 4'd2);

        // Reset in the middle of a conversion
        @(posedge clk);
        #1;
        prod       = 16'd777;
        prod_valid = 1'b1;
        @(posedge clk);
        #1;
        prod_valid = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("abort_busy",  {31'd0, busy}, 32'd0);
        chk("abort_ready", {31'd0, prod_ready}, 32'd1);
        chk("abort_done",  {31'd0, done}, 32'd0);
        chk("abort_seg3",  {25'd0, seg3}, {25'd0, 7'b1111111});
        chk_win("abort", 4'd0, 4'd0, 4'd0);
        rst  = 1'b1;
        seen = 0;
        for (int n = 0; n < 25; n++) begin
            @(posedge clk);
            #1;
            if (done || busy) seen = 1;
        end
        chk("abort_quiet", seen, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
